// File: rtl/alt_vipitc130_fifo_ctrl.sv
// Read-side sequencer for the clocked-video-output line FIFO.
// Handles flush, initial fill to a start level, frame-aligned read start and underflow re-lock.
module alt_vipitc130_fifo_ctrl #(
    parameter int unsigned USEDW_WIDTH  = 11,
    parameter int unsigned START_LEVEL  = 640,
    parameter int unsigned FLUSH_CYCLES = 8,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   in_sof,
    input  logic                   vid_sof,
    input  logic                   vid_de_req,
    input  logic [USEDW_WIDTH-1:0] fifo_rdusedw,
    input  logic                   fifo_rdempty,
    output logic                   fifo_rdreq,
    output logic                   fifo_aclr,
    output logic                   pixel_valid,
    output logic                   locked,
    output logic                   underflow,
    output logic [COUNT_WIDTH-1:0] underflow_count,
    input  logic                   clear_count,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        WAIT_SOF = 3'd2,
        FILL     = 3'd3,
        ARM      = 3'd4,
        RUN      = 3'd5
    } state_e;

    localparam logic [7:0]             FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
    localparam logic [USEDW_WIDTH-1:0] START_LVL  = USEDW_WIDTH'(START_LEVEL);

    state_e                 state_q, state_d;
    logic [7:0]             flush_cnt_q, flush_cnt_d;
    logic                   aclr_q, aclr_d;
    logic                   pixel_valid_q;
    logic                   locked_q, locked_d;
    logic                   underflow_q, underflow_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   rdreq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Disable overrides every transition, including an underflow in the same cycle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) state_d = WAIT_SOF;
                    else                   flush_cnt_d = flush_cnt_q - 8'd1;
                end
                WAIT_SOF: if (in_sof) state_d = FILL;
                FILL:     if (fifo_rdusedw >= START_LVL) state_d = ARM;
                ARM:      if (vid_sof) state_d = RUN;
                RUN: begin
                    if (vid_de_req && fifo_rdempty) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rdreq       = (state_q == RUN) && vid_de_req && !fifo_rdempty;
        underflow_d = (state_q == RUN) && enable && vid_de_req && fifo_rdempty;
        aclr_d      = (state_d == IDLE) || (state_d == FLUSH);
        locked_d    = (state_d == RUN);
        count_d     = count_q;
        if (clear_count)
            count_d = '0;
        else if (underflow_d && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aclr_q        <= 1'b1;
            pixel_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            underflow_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            aclr_q        <= aclr_d;
            pixel_valid_q <= rdreq;
            locked_q      <= locked_d;
            underflow_q   <= underflow_d;
            count_q       <= count_d;
        end
    end

    assign fifo_rdreq      = rdreq;
    assign fifo_aclr       = aclr_q;
    assign pixel_valid     = pixel_valid_q;
    assign locked          = locked_q;
    assign underflow       = underflow_q;
    assign underflow_count = count_q;
    assign state           = state_q;

endmodule

// File: tb/tb_alt_vipitc130_fifo_ctrl.sv
// Directed bench for alt_vipitc130_fifo_ctrl; counter width reduced to 4 so saturation is reachable.
module tb_alt_vipitc130_fifo_ctrl;

    localparam int unsigned UW = 11;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          in_sof;
    logic          vid_sof;
    logic          vid_de_req;
    logic [UW-1:0] fifo_rdusedw;
    logic          fifo_rdempty;
    logic          fifo_rdreq;
    logic          fifo_aclr;
    logic          pixel_valid;
    logic          locked;
    logic          underflow;
    logic [CW-1:0] underflow_count;
    logic          clear_count;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    alt_vipitc130_fifo_ctrl #(
        .USEDW_WIDTH  (UW),
        .START_LEVEL  (640),
        .FLUSH_CYCLES (8),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .in_sof          (in_sof),
        .vid_sof         (vid_sof),
        .vid_de_req      (vid_de_req),
        .fifo_rdusedw    (fifo_rdusedw),
        .fifo_rdempty    (fifo_rdempty),
        .fifo_rdreq      (fifo_rdreq),
        .fifo_aclr       (fifo_aclr),
        .pixel_valid     (pixel_valid),
        .locked          (locked),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .clear_count     (clear_count),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the sequencer from wherever it is in the flush back into RUN.
    task automatic relock();
        int n = 0;
        while (state != 3'd2 && n < 50) begin
            tick();
            n++;
        end
        check("relock_wait_sof", state, 2);
        in_sof = 1'b1;
        tick();
        in_sof = 1'b0;
        fifo_rdusedw = 11'd700;
        tick();
        check("relock_arm", state, 4);
        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        check("relock_run", state, 5);
    endtask

    task automatic do_underflow();
        vid_de_req   = 1'b1;
        fifo_rdempty = 1'b1;
        tick();
        vid_de_req   = 1'b0;
        fifo_rdempty = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fl_cycles;
        int arm_lvl;
        int rq_cnt;
        int pv_cnt;
        int pv_first;

        rst = 1'b1; enable = 1'b0; in_sof = 1'b0; vid_sof = 1'b0;
        vid_de_req = 1'b0; fifo_rdusedw = '0; fifo_rdempty = 1'b0; clear_count = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_aclr", fifo_aclr, 1);
        check("rst_rdreq", fifo_rdreq, 0);
        check("rst_pv", pixel_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_uf", underflow, 0);
        check("rst_count", underflow_count, 0);

        rst = 1'b0;
        tick();
        tick();
        check("idle_hold_state", state, 0);
        check("idle_hold_aclr", fifo_aclr, 1);

        enable = 1'b1;
        tick();
        fl_cycles = 0;
        while (state == 3'd1 && fl_cycles < 40) begin
            if (fifo_aclr) fl_cycles++;
            tick();
        end
        check("flush_aclr_cycles", fl_cycles, 8);
        check("flush_to_wait_sof", state, 2);
        check("wait_sof_aclr", fifo_aclr, 0);

        in_sof = 1'b1;
        tick();
        in_sof = 1'b0;
        check("sof_to_fill", state, 3);

        fifo_rdusedw = 11'd100;
        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        check("fill_ignores_vid_sof", state, 3);

        arm_lvl = -1;
        for (int v = 0; v <= 700; v++) begin
            fifo_rdusedw = 11'(v);
            tick();
            if (state == 3'd4) begin
                arm_lvl = v;
                break;
            end
        end
        check("arm_level", arm_lvl, 640);
        check("arm_not_locked", locked, 0);

        vid_sof = 1'b1;
        tick();
        vid_sof = 1'b0;
        check("arm_to_run", state, 5);
        check("run_locked", locked, 1);
        check("run_pv_idle", pixel_valid, 0);

        rq_cnt = 0; pv_cnt = 0; pv_first = 0;
        for (int i = 0; i < 11; i++) begin
            vid_de_req = (i < 10);
            #1;
            rq_cnt += int'(fifo_rdreq);
            tick();
            pv_cnt += int'(pixel_valid);
            if (i == 0) pv_first = int'(pixel_valid);
        end
        check("rdreq_count", rq_cnt, 10);
        check("pv_count", pv_cnt, 10);
        check("pv_latency", pv_first, 1);
        check("pv_after", pixel_valid, 0);

        vid_de_req = 1'b1;
        fifo_rdempty = 1'b1;
        #1;
        check("uf_rdreq_low", fifo_rdreq, 0);
        tick();
        vid_de_req = 1'b0;
        fifo_rdempty = 1'b0;
        check("uf_pulse", underflow, 1);
        check("uf_count", underflow_count, 1);
        check("uf_unlock", locked, 0);
        check("uf_state", state, 1);
        check("uf_aclr", fifo_aclr, 1);
        tick();
        check("uf_pulse_end", underflow, 0);
        relock();
        check("relock_locked", locked, 1);

        enable = 1'b0;
        vid_de_req = 1'b1;
        fifo_rdempty = 1'b1;
        tick();
        vid_de_req = 1'b0;
        fifo_rdempty = 1'b0;
        check("dis_state", state, 0);
        check("dis_aclr", fifo_aclr, 1);
        check("dis_no_uf", underflow, 0);
        check("dis_count", underflow_count, 1);
        check("dis_unlock", locked, 0);
        enable = 1'b1;
        relock();

        for (int k = 0; k < 14; k++) begin
            do_underflow();
            relock();
        end
        check("count_max", underflow_count, 15);
        do_underflow();
        check("sat_pulse", underflow, 1);
        check("sat_hold", underflow_count, 15);
        relock();

        clear_count = 1'b1;
        do_underflow();
        clear_count = 1'b0;
        check("clr_pulse", underflow, 1);
        check("clr_wins", underflow_count, 0);
        relock();
        do_underflow();
        check("count_after_clr", underflow_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
